// File: rtl/alu_exec_pkg.sv
// Shared constants for the sequential execute controller: op-codes,
// controller state encoding and the default datapath width.
package alu_exec_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_exec_seq_addsub_core.sv
// Combinational adder/subtractor. Subtraction is a + ~b + 1, so cout is
// the "no borrow" indication; ovf is signed overflow of the operation.
module addsub_core #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [W-1:0] bx;

    // Invert the operand for subtraction and add the carry-in
    always_comb begin
        bx          = b ^ {W{sub}};
        {cout, sum} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
        ovf         = (a[W-1] == bx[W-1]) & (sum[W-1] != a[W-1]);
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential execute controller and accumulator. One command at a time:
// LDA retires at accept, ADD/SUB take EXEC + WB, OUT drives the
// accumulator onto the bus for a single cycle.
module alu_exec_seq
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             sub_q, sub_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             fc_q, fc_d;
    logic             fz_q, fz_d;
    logic             fv_q, fv_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    addsub_core #(.W(WIDTH)) u_addsub (
        .a    (acc_q),
        .b    (b_q),
        .sub  (sub_q),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    // Next-state and datapath updates; done is registered so it is
    // set one edge ahead of the cycle it must be seen in
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        res_d   = res_q;
        sub_d   = sub_q;
        c_d     = c_q;
        v_d     = v_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        fv_d    = fv_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LDA: begin
                            acc_d  = bus_in;
                            fz_d   = (bus_in == '0);
                            done_d = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            b_d     = bus_in;
                            sub_d   = cmd_op[1];
                            state_d = S_EXEC;
                        end
                        default: begin
                            state_d = S_OUT;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                res_d   = sum;
                c_d     = cout;
                v_d     = ovf;
                state_d = S_WB;
            end
            S_WB: begin
                acc_d   = res_q;
                fc_d    = c_q;
                fv_d    = v_q;
                fz_d    = (res_q == '0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sub_q   <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            fv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sub_q   <= sub_d;
            c_q     <= c_d;
            v_q     <= v_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            fv_q    <= fv_d;
            done_q  <= done_d;
        end
    end

    // Handshake and bus drive decode straight from state
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        bus_oe    = (state_q == S_OUT);
        bus_out   = bus_oe ? acc_q : '0;
    end

    assign acc    = acc_q;
    assign flag_c = fc_q;
    assign flag_z = fz_q;
    assign flag_v = fv_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: inputs change and outputs are checked
// on the falling edge, expected values are hand-computed constants.
module tb_alu_exec_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] acc;
    logic       flag_c, flag_z, flag_v;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    alu_exec_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .acc       (acc),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check accumulator plus C/Z/V in one go
    task automatic chk_state(input string tag, input logic [7:0] a,
                             input logic c, input logic z, input logic v);
        chk({tag, " acc"}, {24'd0, acc}, {24'd0, a});
        chk({tag, " C"}, {31'd0, flag_c}, {31'd0, c});
        chk({tag, " Z"}, {31'd0, flag_z}, {31'd0, z});
        chk({tag, " V"}, {31'd0, flag_v}, {31'd0, v});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one command for a single edge, then drop valid
    task automatic issue(input logic [1:0] op, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        bus_in    = d;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        bus_in    = 8'h00;
        @(negedge clk);
        step();

        // Reset state
        chk_state("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst oe", {31'd0, bus_oe}, 32'd0);
        chk("rst bus_out", {24'd0, bus_out}, 32'd0);
        rst_n = 1'b1;
        step();

        // Reset mid-ADD: no writeback, everything back to zero
        issue(2'b00, 8'h10);
        chk("lda10 acc", {24'd0, acc}, 32'h10);
        issue(2'b01, 8'h20);
        chk("mid-add ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk_state("post-rst", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post-rst ready", {31'd0, cmd_ready}, 32'd1);
        chk("post-rst done", {31'd0, done}, 32'd0);
        step();
        chk("post-rst acc2", {24'd0, acc}, 32'd0);
        chk("post-rst done2", {31'd0, done}, 32'd0);

        // 0x7F + 0x01: signed overflow
        issue(2'b00, 8'h7F);
        issue(2'b01, 8'h01);
        chk("add7f ready E0", {31'd0, cmd_ready}, 32'd0);
        chk("add7f done E0", {31'd0, done}, 32'd0);
        step();
        chk("add7f ready E1", {31'd0, cmd_ready}, 32'd0);
        chk("add7f acc E1", {24'd0, acc}, 32'h7F);
        chk("add7f done E1", {31'd0, done}, 32'd0);
        step();
        chk_state("add7f", 8'h80, 1'b0, 1'b0, 1'b1);
        chk("add7f done", {31'd0, done}, 32'd1);
        chk("add7f ready", {31'd0, cmd_ready}, 32'd1);
        step();
        chk("add7f done off", {31'd0, done}, 32'd0);

        // 0xFF + 0x01: carry out, zero result
        issue(2'b00, 8'hFF);
        issue(2'b01, 8'h01);
        step();
        step();
        chk_state("addff", 8'h00, 1'b1, 1'b1, 1'b0);

        // Back-to-back LDA with C=1 left from the previous add
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        bus_in    = 8'h00;
        step();
        chk_state("lda00", 8'h00, 1'b1, 1'b1, 1'b0);
        chk("lda00 done", {31'd0, done}, 32'd1);
        chk("lda00 ready", {31'd0, cmd_ready}, 32'd1);
        bus_in = 8'h3C;
        step();
        cmd_valid = 1'b0;
        chk_state("lda3c", 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("lda3c done", {31'd0, done}, 32'd1);
        step();
        chk("lda3c done off", {31'd0, done}, 32'd0);

        // 0x05 - 0x07 borrows; then 0xFE - 0xFE is zero with no borrow
        issue(2'b00, 8'h05);
        issue(2'b10, 8'h07);
        step();
        step();
        chk_state("sub07", 8'hFE, 1'b0, 1'b0, 1'b0);
        chk("sub07 done", {31'd0, done}, 32'd1);
        issue(2'b10, 8'hFE);
        step();
        step();
        chk_state("subfe", 8'h00, 1'b1, 1'b1, 1'b0);

        // OUT with valid held high: one-cycle drive, re-accept two edges later
        issue(2'b00, 8'hA5);
        chk("idle oe", {31'd0, bus_oe}, 32'd0);
        chk("idle bus_out", {24'd0, bus_out}, 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        bus_in    = 8'h00;
        step();
        chk("out1 oe", {31'd0, bus_oe}, 32'd1);
        chk("out1 bus_out", {24'd0, bus_out}, 32'hA5);
        chk("out1 done", {31'd0, done}, 32'd1);
        chk("out1 ready", {31'd0, cmd_ready}, 32'd0);
        step();
        chk("gap oe", {31'd0, bus_oe}, 32'd0);
        chk("gap bus_out", {24'd0, bus_out}, 32'd0);
        chk("gap done", {31'd0, done}, 32'd0);
        chk("gap ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("out2 oe", {31'd0, bus_oe}, 32'd1);
        chk("out2 bus_out", {24'd0, bus_out}, 32'hA5);
        chk("out2 done", {31'd0, done}, 32'd1);
        step();
        chk("after oe", {31'd0, bus_oe}, 32'd0);
        chk("after bus_out", {24'd0, bus_out}, 32'd0);
        chk_state("after out", 8'hA5, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
